rdata_chan_subo_pburst: RTL and testbench

//  Parametrised AXI read-data channel subordinate (successor of the fixed 4x32 one).

---
 rtl/rdata_chan_subo_pburst.sv | 140 ++++++++++++++
 tb/tb_rdata_chan_subo_pburst.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rdata_chan_subo_pburst.sv
// rtl/rdata_chan_subo_pburst.sv - AXI R-channel subordinate: buffers read lines and replays them as bursts
module rdata_chan_subo_pburst #(
    parameter int DATA_W     = 32,
    parameter int BEATS      = 4,
    parameter int ID_W       = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int LINE_W    = DATA_W * BEATS,
    localparam int LEN_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    input  logic              rdata_s_valid,
    output logic              rdata_s_ready,
    input  logic [ID_W-1:0]   rdata_s_id,
    input  logic [1:0]        rdata_s_resp,
    input  logic [LEN_W-1:0]  rdata_s_len,
    input  logic [LINE_W-1:0] rdata_s_data,
    output logic              finish_rdata_s
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    logic [ID_W-1:0]   r_id   [FIFO_DEPTH];
    logic [1:0]        r_resp [FIFO_DEPTH];
    logic [LEN_W-1:0]  r_len  [FIFO_DEPTH];
    logic [LINE_W-1:0] r_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    logic [LEN_W-1:0]  r_beat;

    state_t            w_state_next;
    logic [LEN_W-1:0]  w_beat_next;
    logic              w_push;
    logic              w_pop;
    logic              w_burst;
    logic              w_last;
    logic [CNT_W-1:0]  w_count_next;
    logic [LEN_W-1:0]  w_len_clamped;
    logic [LEN_W-1:0]  w_head_len;
    logic [LINE_W-1:0] w_head_line;
    logic [DATA_W-1:0] w_beat_data;

    // Compared at 32 bits so the clamp stays meaningful when BEATS is not a power of two.
    assign w_len_clamped = ({{(32-LEN_W){1'b0}}, rdata_s_len} > 32'(BEATS - 1))
                           ? LEN_W'(BEATS - 1) : rdata_s_len;

    assign rdata_s_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push        = rdata_s_valid & rdata_s_ready;
    assign w_head_len    = r_len[r_rptr];
    assign w_head_line   = r_data[r_rptr];
    assign w_beat_data   = w_head_line[int'(r_beat)*DATA_W +: DATA_W];
    assign w_burst       = (r_state == S_BURST);
    assign w_last        = w_burst & (r_beat == w_head_len);
    assign w_pop         = w_last & rready;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_id[r_wptr]   <= rdata_s_id;
            r_resp[r_wptr] <= rdata_s_resp;
            r_len[r_wptr]  <= w_len_clamped;
            r_data[r_wptr] <= rdata_s_data;
        end
    end

    // Pointer wrap is explicit so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= S_IDLE;
            r_beat  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_beat_next    = r_beat;
        rvalid         = 1'b0;
        rid            = '0;
        rresp          = '0;
        rdata          = '0;
        rlast          = 1'b0;
        finish_rdata_s = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = S_BURST;
                    w_beat_next  = '0;
                end
            end
            S_BURST: begin
                rvalid = 1'b1;
                rid    = r_id[r_rptr];
                rresp  = r_resp[r_rptr];
                rdata  = w_beat_data;
                rlast  = w_last;
                if (rready) begin
                    if (w_last) begin
                        finish_rdata_s = 1'b1;
                        w_beat_next    = '0;
                        w_state_next   = (w_count_next != '0) ? S_BURST : S_IDLE;
                    end else begin
                        w_beat_next = r_beat + LEN_W'(1);
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rdata_chan_subo_pburst.sv
// tb/tb_rdata_chan_subo_pburst.sv - scoreboard bench for rdata_chan_subo_pburst
module tb_rdata_chan_subo_pburst;
    parameter int DATA_W     = 32;
    parameter int BEATS      = 4;
    parameter int ID_W       = 4;
    parameter int FIFO_DEPTH = 2;
    localparam int LINE_W    = DATA_W * BEATS;
    localparam int LEN_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rdata_s_valid = 1'b0;
    logic              rdata_s_ready;
    logic [ID_W-1:0]   rdata_s_id = '0;
    logic [1:0]        rdata_s_resp = '0;
    logic [LEN_W-1:0]  rdata_s_len = '0;
    logic [LINE_W-1:0] rdata_s_data = '0;
    logic              finish_rdata_s;

    rdata_chan_subo_pburst #(
        .DATA_W(DATA_W), .BEATS(BEATS), .ID_W(ID_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .rdata_s_valid(rdata_s_valid), .rdata_s_ready(rdata_s_ready),
        .rdata_s_id(rdata_s_id), .rdata_s_resp(rdata_s_resp),
        .rdata_s_len(rdata_s_len), .rdata_s_data(rdata_s_data),
        .finish_rdata_s(finish_rdata_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    occ = 0;
    bit    exp_rvalid = 1'b0;
    bit    just_reset = 1'b0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: a line of len L becomes min(L,BEATS-1)+1 beats taken in order from the low end.
    function automatic void model_push(logic [ID_W-1:0] id, logic [1:0] resp,
                                       int len, logic [LINE_W-1:0] line);
        int eff;
        beat_t b;
        eff = (len > BEATS - 1) ? BEATS - 1 : len;
        for (int i = 0; i <= eff; i++) begin
            b.id   = id;
            b.resp = resp;
            b.data = line[i*DATA_W +: DATA_W];
            b.last = (i == eff);
            exp_q.push_back(b);
        end
    endfunction

    always @(negedge clk) begin : monitor
        int    occ_before;
        beat_t b;
        if (rst) begin
            exp_q.delete();
            occ        = 0;
            exp_rvalid = 1'b0;
            just_reset = 1'b1;
        end else begin
            occ_before = occ;
            chk("rvalid", rvalid, exp_rvalid);
            chk("s_ready", rdata_s_ready, occ_before < FIFO_DEPTH);
            if (just_reset) begin
                chk("reset_rid", rid, 0);
                chk("reset_rdata", rdata, 0);
                chk("reset_rresp", rresp, 0);
                chk("reset_rlast", rlast, 0);
                just_reset = 1'b0;
            end
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=rvalid required=no_beat");
                end else begin
                    b = exp_q[0];
                    chk("rid", rid, b.id);
                    chk("rresp", rresp, b.resp);
                    chk("rdata", rdata, b.data);
                    chk("rlast", rlast, b.last);
                    chk("finish", finish_rdata_s, rready && b.last);
                    if (rready) begin
                        void'(exp_q.pop_front());
                        if (b.last) occ--;
                    end
                end
            end else begin
                chk("finish_idle", finish_rdata_s, 0);
            end
            if (rdata_s_valid && occ_before < FIFO_DEPTH) begin
                model_push(rdata_s_id, rdata_s_resp, int'(rdata_s_len), rdata_s_data);
                occ++;
            end
            // A burst is presented in a cycle only if a line was held both before and after the edge.
            exp_rvalid = (occ_before > 0) && (occ > 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [ID_W-1:0] id, input logic [1:0] resp,
                             input int len, input logic [LINE_W-1:0] line);
        bit got;
        got          = 1'b0;
        rdata_s_id   = id;
        rdata_s_resp = resp;
        rdata_s_len  = LEN_W'(len);
        rdata_s_data = line;
        rdata_s_valid = 1'b1;
        for (int t = 0; t < 500 && !got; t++) begin
            @(negedge clk);
            got = rdata_s_ready;
            @(posedge clk);
            #1;
        end
        rdata_s_valid = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=not_taken required=taken");
        end
    endtask

    function automatic logic [LINE_W-1:0] pattern_line();
        logic [LINE_W-1:0] l;
        for (int b = 0; b < BEATS; b++)
            for (int n = 0; n < DATA_W / 4; n++)
                l[b*DATA_W + 4*n +: 4] = 4'((b + 1) % 16);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W; i++) l[i] = 1'($urandom);
        return l;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();

        rready = 1'b1;
        push_line(5, 0, 3, pattern_line());
        repeat (8) step();

        push_line(5, 0, 3, pattern_line());
        step();
        rready = 1'b0;
        repeat (3) step();
        rready = 1'b1;
        repeat (8) step();

        push_line(1, 0, 3, rand_line());
        push_line(2, 0, 3, rand_line());
        repeat (12) step();

        push_line(3, 2, 0, rand_line());
        repeat (4) step();
        push_line(4, 0, 7, rand_line());
        repeat (10) step();

        rready = 1'b0;
        fork
            begin
                push_line(8, 0, 3, rand_line());
                push_line(9, 1, 2, rand_line());
                push_line(10, 0, 1, rand_line());
            end
            begin
                repeat (8) step();
                rready = 1'b1;
            end
        join
        repeat (20) step();

        push_line(6, 0, 3, pattern_line());
        repeat (2) step();
        rst = 1'b1;
        rready = 1'b0;
        step();
        rst = 1'b0;
        rready = 1'b1;
        step();
        push_line(7, 1, 3, pattern_line());
        repeat (10) step();

        for (int c = 0; c < 1500; c++) begin
            rready        = ($urandom % 4) != 0;
            rdata_s_valid = ($urandom % 3) == 0;
            rdata_s_id    = ID_W'($urandom);
            rdata_s_resp  = 2'($urandom);
            rdata_s_len   = LEN_W'($urandom);
            rdata_s_data  = rand_line();
            step();
        end
        rdata_s_valid = 1'b0;
        rready = 1'b1;
        for (int t = 0; t < 300 && (exp_q.size() != 0 || occ != 0); t++) step();
        step();
        chk("drain_beats", exp_q.size(), 0);
        chk("drain_lines", occ, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
